vx_raster_csr_responder: RTL and testbench

//  Responder end of VX_sfu_csr_if for the raster extension. Holds per-warp, per-thread stamp

---
 rtl/vx_raster_csr_responder_pkg.sv | 38 +++
 rtl/vx_raster_csr_responder_store.sv | 61 ++++++
 rtl/vx_raster_csr_responder.sv | 123 ++++++++++++
 tb/tb_vx_raster_csr_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vx_raster_csr_responder_pkg.sv
// Shared definitions for the raster CSR responder: CSR address map,
// stamp record layout and interface field widths.
package vx_raster_csr_responder_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int UUID_W     = 44;

  localparam int VX_RASTER_CSR_WORDS = 13;

  // Raster CSR window; word offsets below are relative to this base.
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BEGIN = 12'h7C0;

  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_POS_MASK  = 12'd0;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_X0 = 12'd1;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_X1 = 12'd2;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_X2 = 12'd3;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_X3 = 12'd4;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Y0 = 12'd5;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Y1 = 12'd6;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Y2 = 12'd7;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Y3 = 12'd8;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Z0 = 12'd9;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Z1 = 12'd10;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Z2 = 12'd11;
  localparam logic [CSR_ADDR_W-1:0] VX_CSR_RASTER_BCOORD_Z3 = 12'd12;

  // One thread's stamp record; pos_mask sits in the LSBs (word 0).
  typedef struct packed {
    logic [11:0][31:0] bcoords;
    logic [31:0]       pos_mask;
  } raster_stamp_t;

  // Offset legality check for the raster CSR window.
  function automatic logic raster_off_legal(input logic [CSR_ADDR_W-1:0] off, input int words);
    return off < CSR_ADDR_W'(words);
  endfunction

endpackage

// File: rtl/vx_raster_csr_responder_store.sv
// Per-warp, per-thread stamp record array. One thread-masked write port
// (fill) and one asynchronous read port returning NUM_LANES records
// selected by pid. Also tracks which warps have ever been filled.
module vx_raster_csr_responder_store #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4,
  parameter int NUM_WORDS   = 13,
  parameter int NW_W        = 2,
  parameter int PID_W       = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         wr_en,
  input  logic [NW_W-1:0]                              wr_wid,
  input  logic [NUM_THREADS-1:0]                       wr_tmask,
  input  logic [NUM_THREADS-1:0][NUM_WORDS-1:0][31:0]  wr_data,
  input  logic [NW_W-1:0]                              rd_wid,
  input  logic [PID_W-1:0]                             rd_pid,
  output logic [NUM_LANES-1:0][NUM_WORDS-1:0][31:0]    rd_rec,
  output logic [NUM_WARPS-1:0]                         warp_valid
);

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [NUM_WARPS-1:0][NUM_THREADS-1:0][NUM_WORDS-1:0][31:0] store_q, store_d;
  logic [NUM_WARPS-1:0]                                       warp_valid_q, warp_valid_d;

  // Next-state: masked threads of the target warp take the new record.
  always_comb begin
    store_d      = store_q;
    warp_valid_d = warp_valid_q;
    if (wr_en) begin
      warp_valid_d[wr_wid] = 1'b1;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (wr_tmask[t]) store_d[wr_wid][t] = wr_data[t];
      end
    end
  end

  // Storage and valid bits; async reset drops every record at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q      <= '0;
      warp_valid_q <= '0;
    end else begin
      store_q      <= store_d;
      warp_valid_q <= warp_valid_d;
    end
  end

  // Read port: lane i maps to thread pid*NUM_LANES+i, no fill bypass.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [TID_W-1:0] tid;
    assign tid       = TID_W'(int'(rd_pid) * NUM_LANES + i);
    assign rd_rec[i] = store_q[rd_wid][tid];
  end

  assign warp_valid = warp_valid_q;

endmodule

// File: rtl/vx_raster_csr_responder.sv
// Raster CSR responder: serves read-only stamp CSRs to the CSR unit with
// zero latency, accepts stamp fills from the raster fetch path, and keeps
// saturating counts of reads and rejected writes.
module vx_raster_csr_responder
  import vx_raster_csr_responder_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 1,
  parameter int NUM_WORDS   = VX_RASTER_CSR_WORDS,
  parameter int CNT_W       = 32,
  localparam int NW_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int PID_W      = (NUM_THREADS / NUM_LANES > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // CSR read request / response
  input  logic                                 read_enable,
  input  logic [UUID_W-1:0]                    read_uuid,
  input  logic [NW_W-1:0]                      read_wid,
  input  logic [NUM_LANES-1:0]                 read_tmask,
  input  logic [PID_W-1:0]                     read_pid,
  input  logic [CSR_ADDR_W-1:0]                read_addr,
  output logic [NUM_LANES-1:0][31:0]           read_data,
  // CSR write request (always rejected)
  input  logic                                 write_enable,
  input  logic [UUID_W-1:0]                    write_uuid,
  input  logic [NW_W-1:0]                      write_wid,
  input  logic [NUM_LANES-1:0]                 write_tmask,
  input  logic [PID_W-1:0]                     write_pid,
  input  logic [CSR_ADDR_W-1:0]                write_addr,
  input  logic [NUM_LANES-1:0][31:0]           write_data,
  // Stamp fill
  input  logic                                 fill_valid,
  output logic                                 fill_ready,
  input  logic [NW_W-1:0]                      fill_wid,
  input  logic [NUM_THREADS-1:0]               fill_tmask,
  input  logic [NUM_THREADS*NUM_WORDS*32-1:0]  fill_data,
  // Perf
  output logic [CNT_W-1:0]                     perf_reads,
  output logic [CNT_W-1:0]                     perf_bad_wr
);

  localparam int WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [NUM_LANES-1:0][NUM_WORDS-1:0][31:0] rd_rec;
  logic [NUM_WARPS-1:0]                      warp_valid;
  logic [CSR_ADDR_W-1:0]                     off;
  logic                                      off_legal;
  logic [WIDX_W-1:0]                         widx;
  logic                                      rd_hit;
  logic [CNT_W-1:0]                          perf_reads_q, perf_reads_d;
  logic [CNT_W-1:0]                          perf_bad_wr_q, perf_bad_wr_d;

  assign fill_ready = ~reset;

  vx_raster_csr_responder_store #(
    .NUM_WARPS   (NUM_WARPS),
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES),
    .NUM_WORDS   (NUM_WORDS),
    .NW_W        (NW_W),
    .PID_W       (PID_W)
  ) store (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (fill_valid),
    .wr_wid     (fill_wid),
    .wr_tmask   (fill_tmask),
    .wr_data    (fill_data),
    .rd_wid     (read_wid),
    .rd_pid     (read_pid),
    .rd_rec     (rd_rec),
    .warp_valid (warp_valid)
  );

  // Address decode; an illegal offset forces word 0 so the mux index stays in range.
  always_comb begin
    off       = read_addr - VX_CSR_RASTER_BEGIN;
    off_legal = raster_off_legal(off, NUM_WORDS);
    widx      = off_legal ? WIDX_W'(off) : '0;
    rd_hit    = off_legal && warp_valid[read_wid];
  end

  // Per-lane word select, zeroed for masked lanes, illegal offsets and unfilled warps.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_rd
    assign read_data[i] = (rd_hit && read_tmask[i]) ? rd_rec[i][widx] : 32'h0;
  end

  // Saturating perf counters: every read cycle, every write cycle.
  always_comb begin
    perf_reads_d  = perf_reads_q;
    perf_bad_wr_d = perf_bad_wr_q;
    if (read_enable && (perf_reads_q != '1))   perf_reads_d  = perf_reads_q + CNT_W'(1);
    if (write_enable && (perf_bad_wr_q != '1)) perf_bad_wr_d = perf_bad_wr_q + CNT_W'(1);
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads_q  <= '0;
      perf_bad_wr_q <= '0;
    end else begin
      perf_reads_q  <= perf_reads_d;
      perf_bad_wr_q <= perf_bad_wr_d;
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_bad_wr = perf_bad_wr_q;

  // Trace-only request fields; writes are rejected without looking at their payload.
  logic unused_ok;
  assign unused_ok = ^{read_uuid, write_uuid, write_wid, write_tmask, write_pid,
                       write_addr, write_data};

  // Request sanity: fills target an existing warp, reads stay inside the warp.
  always_ff @(posedge clk) begin
    if (!reset && fill_valid)  assert (int'(fill_wid) < NUM_WARPS);
    if (!reset && read_enable) assert (int'(read_pid) * NUM_LANES < NUM_THREADS);
  end

endmodule

// File: tb/tb_vx_raster_csr_responder.sv
// Directed bench for the raster CSR responder (4 warps, 8 threads, 4 lanes,
// 4-bit counters so saturation is reachable in a few cycles).
module tb_vx_raster_csr_responder;
  import vx_raster_csr_responder_pkg::*;

  localparam int NWARP = 4;
  localparam int NTHR  = 8;
  localparam int NLANE = 4;
  localparam int NWORD = 13;
  localparam int CW    = 4;
  localparam logic [11:0] B = VX_CSR_RASTER_BEGIN;

  logic clk = 1'b0;
  logic reset;
  logic read_enable, write_enable, fill_valid, fill_ready;
  logic [UUID_W-1:0] read_uuid, write_uuid;
  logic [1:0] read_wid, write_wid, fill_wid;
  logic [NLANE-1:0] read_tmask, write_tmask;
  logic read_pid, write_pid;
  logic [11:0] read_addr, write_addr;
  logic [NLANE-1:0][31:0] read_data, write_data;
  logic [NTHR-1:0] fill_tmask;
  logic [NTHR-1:0][NWORD-1:0][31:0] fd;
  logic [CW-1:0] perf_reads, perf_bad_wr;

  int total = 0;
  int bad   = 0;
  int exp_rd = 0;

  always #5 clk = ~clk;

  vx_raster_csr_responder #(
    .NUM_WARPS(NWARP), .NUM_THREADS(NTHR), .NUM_LANES(NLANE), .NUM_WORDS(NWORD), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid),
    .read_tmask(read_tmask), .read_pid(read_pid), .read_addr(read_addr), .read_data(read_data),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
    .write_tmask(write_tmask), .write_pid(write_pid), .write_addr(write_addr),
    .write_data(write_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_wid(fill_wid),
    .fill_tmask(fill_tmask), .fill_data(fd),
    .perf_reads(perf_reads), .perf_bad_wr(perf_bad_wr)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [1:0] w, input logic p, input logic [3:0] m);
    read_enable = 1'b1; read_addr = a; read_wid = w; read_pid = p; read_tmask = m;
    #1;
  endtask

  task automatic rd_done();
    tick();
    read_enable = 1'b0;
    if (exp_rd < 15) exp_rd++;
  endtask

  task automatic fill(input logic [1:0] w, input logic [7:0] m);
    fill_valid = 1'b1; fill_wid = w; fill_tmask = m;
    tick();
    fill_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    read_enable = 0; read_uuid = '0; read_wid = 0; read_tmask = 0; read_pid = 0; read_addr = 0;
    write_enable = 0; write_uuid = '0; write_wid = 0; write_tmask = 0; write_pid = 0;
    write_addr = 0; write_data = '0;
    fill_valid = 0; fill_wid = 0; fill_tmask = 0; fd = '0;
    #1;
    chk("rst_fill_ready", 128'(fill_ready), 128'd0);
    chk("rst_perf_reads", 128'(perf_reads), 128'd0);
    chk("rst_perf_bad_wr", 128'(perf_bad_wr), 128'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("fill_ready_up", 128'(fill_ready), 128'd1);

    // 1: read of an unfilled warp
    rd(B, 2'd0, 1'b0, 4'b0001);
    chk("t1_rdata", 128'(read_data), 128'd0);
    rd_done();
    chk("t1_perf_reads", 128'(perf_reads), 128'd1);

    // 2: full fill of warp 2, read back the upper lane group
    fd = '0;
    for (int t = 0; t < NTHR; t++) begin
      fd[t][0] = 32'h100 + t;
      fd[t][5] = 32'hA0 + t;
    end
    fill(2'd2, 8'hFF);
    rd(B, 2'd2, 1'b1, 4'hF);
    chk("t2_word0", 128'(read_data), {32'h107, 32'h106, 32'h105, 32'h104});
    rd_done();
    rd(B + 12'd5, 2'd2, 1'b1, 4'hF);
    chk("t2_word5", 128'(read_data), {32'hA7, 32'hA6, 32'hA5, 32'hA4});
    rd_done();

    // 3: partial fill keeps unmasked threads; masked read lane returns 0
    fd = '1;
    fill(2'd1, 8'hFF);
    fd = '0;
    for (int t = 0; t < NTHR; t++) fd[t][0] = 32'h55 + t;
    fill(2'd1, 8'h0F);
    rd(B, 2'd1, 1'b0, 4'b1011);
    chk("t3_new_lanes", 128'(read_data), {32'h58, 32'h0, 32'h56, 32'h55});
    rd_done();
    rd(B, 2'd1, 1'b1, 4'hF);
    chk("t3_old_lanes", 128'(read_data), {4{32'hFFFF_FFFF}});
    rd_done();

    // 4: fill and read of the same warp in one cycle returns old contents
    fd = '0;
    for (int t = 0; t < NTHR; t++) fd[t][0] = 32'h11;
    fill(2'd3, 8'hFF);
    for (int t = 0; t < NTHR; t++) fd[t][0] = 32'h22;
    fill_valid = 1'b1; fill_wid = 2'd3; fill_tmask = 8'hFF;
    rd(B, 2'd3, 1'b0, 4'b0001);
    chk("t4_same_cycle", 128'(read_data), 128'h11);
    rd_done();
    fill_valid = 1'b0;
    rd(B, 2'd3, 1'b0, 4'b0001);
    chk("t4_next_cycle", 128'(read_data), 128'h22);
    rd_done();

    // 5: writes rejected and counted, out-of-range read is 0
    write_enable = 1'b1; write_addr = B; write_data = '1; write_tmask = 4'hF;
    rd(B + 12'd13, 2'd2, 1'b1, 4'hF);
    chk("t5_oob_read", 128'(read_data), 128'd0);
    rd_done();
    write_addr = B + 12'd20;
    tick();
    write_enable = 1'b0;
    chk("t5_bad_wr2", 128'(perf_bad_wr), 128'd2);
    rd(B, 2'd2, 1'b1, 4'hF);
    chk("t5_store_kept", 128'(read_data), {32'h107, 32'h106, 32'h105, 32'h104});
    rd_done();
    chk("t5_perf_reads", 128'(perf_reads), 128'(exp_rd));
    write_enable = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    write_enable = 1'b0;
    chk("t5_bad_wr_sat", 128'(perf_bad_wr), 128'd15);
    for (int k = 0; k < 10; k++) begin
      rd(B, 2'd0, 1'b0, 4'h1);
      rd_done();
    end
    chk("t5_reads_sat", 128'(perf_reads), 128'(exp_rd));
    chk("t5_reads_sat15", 128'(perf_reads), 128'd15);

    // 6: async reset between fill and read clears everything without a clock edge
    fd = '0;
    for (int t = 0; t < NTHR; t++) fd[t][0] = 32'h77;
    fill(2'd0, 8'hFF);
    rd(B, 2'd0, 1'b0, 4'hF);
    chk("t6_pre_reset", 128'(read_data), {4{32'h77}});
    #2 reset = 1'b1;
    #1;
    chk("t6_rdata_rst", 128'(read_data), 128'd0);
    chk("t6_ready_rst", 128'(fill_ready), 128'd0);
    chk("t6_reads_rst", 128'(perf_reads), 128'd0);
    chk("t6_badwr_rst", 128'(perf_bad_wr), 128'd0);
    read_enable = 1'b0;
    @(negedge clk); reset = 1'b0;
    exp_rd = 0;
    rd(B, 2'd0, 1'b0, 4'hF);
    chk("t6_w0_cleared", 128'(read_data), 128'd0);
    rd_done();
    rd(B, 2'd2, 1'b1, 4'hF);
    chk("t6_w2_cleared", 128'(read_data), 128'd0);
    rd_done();
    chk("t6_reads_after", 128'(perf_reads), 128'(exp_rd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
